lane_demux: RTL and testbench

LANE_DEMUX -- requirements
Module: lane_demux

---
 rtl/lane_demux_pkg.sv | 18 +
 rtl/lane_demux_if.sv | 24 ++
 rtl/lane_demux_sat_counter.sv | 31 +++
 rtl/lane_demux.sv | 70 +++++++
 tb/tb_lane_demux.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lane_demux_pkg.sv
// Shared kernel constants for the 2:1 time-division lane mux and its demux.
// The phase encoding here is the single source of truth for both ends of the link.
package lane_demux_pkg;

    localparam logic PHASE_A = 1'b1;
    localparam logic PHASE_B = 1'b0;

    typedef enum logic {
        PH_B = PHASE_B,
        PH_A = PHASE_A
    } phase_e;

    // Phase that follows the current one given the stream enable.
    function automatic logic next_phase(input logic phase, input logic enable);
        return enable ? ~phase : PHASE_A;
    endfunction

endpackage

// File: rtl/lane_demux_if.sv
// Stream-side and result-side signals of the lane demultiplexer.
// master drives the interleaved stream; slave is the demux itself.
interface lane_demux_if #(
    parameter int N  = 8,
    parameter int CW = 16
);
    logic          enable;
    logic [N-1:0]  data_in;
    logic [N-1:0]  data_out_a;
    logic [N-1:0]  data_out_b;
    logic          valid_out;
    logic [CW-1:0] pair_count;
    logic [CW-1:0] orphan_count;

    modport master (
        output enable, data_in,
        input  data_out_a, data_out_b, valid_out, pair_count, orphan_count
    );

    modport slave (
        input  enable, data_in,
        output data_out_a, data_out_b, valid_out, pair_count, orphan_count
    );
endinterface

// File: rtl/lane_demux_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CW{1'b1}})) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lane_demux.sv
// Splits an A/B interleaved stream back into registered lane pairs and counts
// completed pairs and lane A words abandoned when the stream drops mid-pair.
module lane_demux
    import lane_demux_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 16
) (
    input logic        clk,
    input logic        reset,
    lane_demux_if.slave bus
);

    phase_e       phase_q;
    logic [N-1:0] hold_a_q;
    logic [N-1:0] data_a_q;
    logic [N-1:0] data_b_q;
    logic         valid_q;

    logic pair_inc;
    logic orphan_inc;

    // Counter increments line up with the edge that loads the pair, so the
    // count is already updated in the cycle valid_out is high.
    assign pair_inc   = bus.enable && (phase_q == PH_B);
    assign orphan_inc = !bus.enable && (phase_q == PH_B);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q  <= PH_A;
            hold_a_q <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            phase_q <= phase_e'(next_phase(phase_q, bus.enable));
            if (bus.enable) begin
                case (phase_q)
                    PH_A: hold_a_q <= bus.data_in;
                    PH_B: begin
                        data_a_q <= hold_a_q;
                        data_b_q <= bus.data_in;
                        valid_q  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    sat_counter #(.CW(CW)) u_pair_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pair_inc),
        .count (bus.pair_count)
    );

    sat_counter #(.CW(CW)) u_orphan_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (orphan_inc),
        .count (bus.orphan_count)
    );

    assign bus.data_out_a = data_a_q;
    assign bus.data_out_b = data_b_q;
    assign bus.valid_out  = valid_q;

endmodule

// File: tb/tb_lane_demux.sv
// Directed checks of lane_demux: reset, pairing, orphans, reset priority,
// counter saturation (narrow instance) and a loopback through a 2:1 mux model.
module tb_lane_demux;
    import lane_demux_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    lane_demux_if #(.N(8), .CW(16)) bus  ();
    lane_demux_if #(.N(8), .CW(2))  bus2 ();

    lane_demux #(.N(8), .CW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    lane_demux #(.N(8), .CW(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    // One clock with the given stream inputs on both instances; outputs are
    // then observed 1 ns after the edge.
    task automatic cyc(input logic en, input logic [7:0] d);
        bus.enable   = en;
        bus.data_in  = d;
        bus2.enable  = en;
        bus2.data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b1, 8'h5A);
        cyc(1'b0, 8'h00);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (bus.valid_out !== 1'b0) $display("FAIL reset_valid got=%b want=0", bus.valid_out);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_out_a !== 8'h00 || bus.data_out_b !== 8'h00)
            $display("FAIL reset_data got=%h/%h want=00/00", bus.data_out_a, bus.data_out_b);
        else pass_cnt++;
        total_cnt++;
        if (bus.pair_count !== 16'd0 || bus.orphan_count !== 16'd0)
            $display("FAIL reset_counts got=%0d/%0d want=0/0", bus.pair_count, bus.orphan_count);
        else pass_cnt++;
        $display("reset: valid=%b a=%h b=%h pairs=%0d orphans=%0d",
                 bus.valid_out, bus.data_out_a, bus.data_out_b, bus.pair_count, bus.orphan_count);
    endtask

    task automatic test_single_pair();
        do_reset();
        cyc(1'b1, 8'h11);
        total_cnt++;
        if (bus.valid_out !== 1'b0) $display("FAIL single_early_valid got=%b want=0", bus.valid_out);
        else pass_cnt++;
        cyc(1'b1, 8'h22);
        total_cnt++;
        if (bus.valid_out !== 1'b1 || bus.data_out_a !== 8'h11 || bus.data_out_b !== 8'h22 ||
            bus.pair_count !== 16'd1)
            $display("FAIL single_pair got=v%b %h/%h pc=%0d want=v1 11/22 pc=1",
                     bus.valid_out, bus.data_out_a, bus.data_out_b, bus.pair_count);
        else pass_cnt++;
        $display("single: pair a=%h b=%h pairs=%0d", bus.data_out_a, bus.data_out_b, bus.pair_count);
        cyc(1'b0, 8'hFF);
        total_cnt++;
        if (bus.valid_out !== 1'b0 || bus.data_out_a !== 8'h11 || bus.data_out_b !== 8'h22)
            $display("FAIL single_hold got=v%b %h/%h want=v0 11/22",
                     bus.valid_out, bus.data_out_a, bus.data_out_b);
        else pass_cnt++;
    endtask

    task automatic test_continuous();
        int pulses;
        logic [7:0] exp_a;
        pulses = 0;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 8'(i));
            total_cnt++;
            if (bus.valid_out !== ((i % 2) == 0))
                $display("FAIL cont_valid cyc=%0d got=%b want=%b", i, bus.valid_out, (i % 2) == 0);
            else pass_cnt++;
            if ((i % 2) == 0) begin
                pulses++;
                exp_a = 8'(i - 1);
                total_cnt++;
                if (bus.data_out_a !== exp_a || bus.data_out_b !== 8'(i))
                    $display("FAIL cont_pair got=%h/%h want=%h/%h",
                             bus.data_out_a, bus.data_out_b, exp_a, 8'(i));
                else pass_cnt++;
                $display("continuous: pair a=%h b=%h", bus.data_out_a, bus.data_out_b);
            end
        end
        total_cnt++;
        if (bus.pair_count !== 16'd4 || pulses != 4)
            $display("FAIL cont_count got=%0d want=4", bus.pair_count);
        else pass_cnt++;
    endtask

    task automatic test_orphan();
        do_reset();
        cyc(1'b1, 8'hAA);
        cyc(1'b0, 8'h00);
        total_cnt++;
        if (bus.valid_out !== 1'b0 || bus.orphan_count !== 16'd1)
            $display("FAIL orphan_drop got=v%b oc=%0d want=v0 oc=1", bus.valid_out, bus.orphan_count);
        else pass_cnt++;
        cyc(1'b1, 8'hBB);
        total_cnt++;
        if (bus.valid_out !== 1'b0) $display("FAIL orphan_fresh_a got=%b want=0", bus.valid_out);
        else pass_cnt++;
        cyc(1'b1, 8'hCC);
        total_cnt++;
        if (bus.valid_out !== 1'b1 || bus.data_out_a !== 8'hBB || bus.data_out_b !== 8'hCC ||
            bus.pair_count !== 16'd1 || bus.orphan_count !== 16'd1)
            $display("FAIL orphan_pair got=v%b %h/%h pc=%0d oc=%0d want=v1 bb/cc pc=1 oc=1",
                     bus.valid_out, bus.data_out_a, bus.data_out_b, bus.pair_count, bus.orphan_count);
        else pass_cnt++;
        $display("orphan: pair a=%h b=%h orphans=%0d", bus.data_out_a, bus.data_out_b, bus.orphan_count);
    endtask

    task automatic test_reset_mid_pair();
        do_reset();
        cyc(1'b1, 8'h11);
        reset = 1'b1;
        cyc(1'b1, 8'h22);
        reset = 1'b0;
        total_cnt++;
        if (bus.valid_out !== 1'b0 || bus.data_out_a !== 8'h00 || bus.data_out_b !== 8'h00 ||
            bus.pair_count !== 16'd0 || bus.orphan_count !== 16'd0)
            $display("FAIL rst_mid got=v%b %h/%h pc=%0d oc=%0d want=v0 00/00 pc=0 oc=0",
                     bus.valid_out, bus.data_out_a, bus.data_out_b, bus.pair_count, bus.orphan_count);
        else pass_cnt++;
        cyc(1'b1, 8'h33);
        total_cnt++;
        if (bus.valid_out !== 1'b0 || bus.orphan_count !== 16'd0)
            $display("FAIL rst_mid_after got=v%b oc=%0d want=v0 oc=0", bus.valid_out, bus.orphan_count);
        else pass_cnt++;
        cyc(1'b1, 8'h44);
        total_cnt++;
        if (bus.valid_out !== 1'b1 || bus.data_out_a !== 8'h33 || bus.data_out_b !== 8'h44)
            $display("FAIL rst_mid_pair got=v%b %h/%h want=v1 33/44",
                     bus.valid_out, bus.data_out_a, bus.data_out_b);
        else pass_cnt++;
        $display("reset_mid: pair a=%h b=%h", bus.data_out_a, bus.data_out_b);
    endtask

    task automatic test_saturation();
        int pulses;
        pulses = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'(8'h40 + i));
            if (bus2.valid_out === 1'b1) pulses++;
        end
        total_cnt++;
        if (pulses != 5) $display("FAIL sat_pulses got=%0d want=5", pulses);
        else pass_cnt++;
        total_cnt++;
        if (bus2.pair_count !== 2'd3 || bus.pair_count !== 16'd5)
            $display("FAIL sat_pairs got=%0d/%0d want=3/5", bus2.pair_count, bus.pair_count);
        else pass_cnt++;
        total_cnt++;
        if (bus2.data_out_a !== 8'h48 || bus2.data_out_b !== 8'h49)
            $display("FAIL sat_last_pair got=%h/%h want=48/49", bus2.data_out_a, bus2.data_out_b);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'hE0);
            cyc(1'b0, 8'h00);
        end
        total_cnt++;
        if (bus2.orphan_count !== 2'd3 || bus.orphan_count !== 16'd4)
            $display("FAIL sat_orphans got=%0d/%0d want=3/4", bus2.orphan_count, bus.orphan_count);
        else pass_cnt++;
        $display("saturation: pulses=%0d pairs=%0d orphans=%0d", pulses, bus2.pair_count, bus2.orphan_count);
    endtask

    // Upstream mux: lane A while its phase says PHASE_A, lane B otherwise.
    task automatic test_loopback();
        logic       mux_ph;
        logic       en;
        logic       exp_v;
        logic [7:0] la, lb, din, exp_a, exp_b, held_a;
        held_a = 8'h00;
        exp_a  = 8'h00;
        exp_b  = 8'h00;
        mux_ph = PHASE_A;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            la    = 8'($urandom);
            lb    = 8'($urandom);
            din   = (mux_ph == PHASE_A) ? la : lb;
            exp_v = en && (mux_ph == PHASE_B);
            if (en && mux_ph == PHASE_A) held_a = la;
            if (exp_v) begin
                exp_a = held_a;
                exp_b = lb;
            end
            mux_ph = en ? ~mux_ph : PHASE_A;
            cyc(en, din);
            total_cnt++;
            if (bus.valid_out !== exp_v)
                $display("FAIL loop_valid cyc=%0d got=%b want=%b", i, bus.valid_out, exp_v);
            else pass_cnt++;
            total_cnt++;
            if (bus.data_out_a !== exp_a || bus.data_out_b !== exp_b)
                $display("FAIL loop_data cyc=%0d got=%h/%h want=%h/%h",
                         i, bus.data_out_a, bus.data_out_b, exp_a, exp_b);
            else pass_cnt++;
            if (exp_v) $display("loopback: pair a=%h b=%h", bus.data_out_a, bus.data_out_b);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.data_in  = 8'h00;
        bus2.enable  = 1'b0;
        bus2.data_in = 8'h00;
        test_reset();
        test_single_pair();
        test_continuous();
        test_orphan();
        test_reset_mid_pair();
        test_saturation();
        test_loopback();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
